// File: rtl/dma_mem_arbiter_if.sv
// Avalon-MM single-word master bus between the DMA arbiter and the memory slave.
// Burst length is always 1 and all byte lanes are enabled, so no byteenable/burstcount.
interface dma_mem_arbiter_if;
   logic [31:0] mem_address;
   logic [31:0] mem_writedata;
   logic        mem_read;
   logic        mem_write;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;
   logic        mem_readdatavalid;

   modport master (
      output mem_address,
      output mem_writedata,
      output mem_read,
      output mem_write,
      input  mem_waitrequest,
      input  mem_readdata,
      input  mem_readdatavalid
   );

   modport slave (
      input  mem_address,
      input  mem_writedata,
      input  mem_read,
      input  mem_write,
      output mem_waitrequest,
      output mem_readdata,
      output mem_readdatavalid
   );
endinterface

// File: rtl/dma_mem_arbiter.sv
// Two-channel round-robin arbiter feeding single-word DMA requests onto one Avalon-MM master,
// with one outstanding transaction at a time and a read-response timeout.
module dma_mem_arbiter #(
   parameter int TIMEOUT = 1023
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ch0_rd,
   input  logic              ch0_wr,
   input  logic [31:0]       ch0_addr,
   input  logic [31:0]       ch0_wdata,
   output logic              ch0_busy,
   output logic [31:0]       ch0_rdata,
   output logic              ch0_err,
   input  logic              ch1_rd,
   input  logic              ch1_wr,
   input  logic [31:0]       ch1_addr,
   input  logic [31:0]       ch1_wdata,
   output logic              ch1_busy,
   output logic [31:0]       ch1_rdata,
   output logic              ch1_err,
   dma_mem_arbiter_if.master mem
);

   typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

   localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [1:0]       slot_valid, slot_is_wr, err_q;
   logic [1:0][31:0] slot_addr, slot_wdata, rdata_q;
   logic [1:0]       strobe_rd, strobe_wr;
   logic [1:0][31:0] strobe_addr, strobe_wdata;
   logic             grant, grant_nxt, last_grant, last_grant_nxt, pick;
   logic [9:0]       wait_cnt, wait_cnt_nxt;
   logic             mem_read_q, mem_read_nxt, mem_write_q, mem_write_nxt;
   logic [31:0]      mem_address_q, mem_address_nxt, mem_writedata_q, mem_writedata_nxt;
   logic             done_wr, done_rd, done_timeout;

   assign strobe_rd    = {ch1_rd, ch0_rd};
   assign strobe_wr    = {ch1_wr, ch0_wr};
   assign strobe_addr  = {ch1_addr, ch0_addr};
   assign strobe_wdata = {ch1_wdata, ch0_wdata};

   assign ch0_busy  = slot_valid[0];
   assign ch1_busy  = slot_valid[1];
   assign ch0_rdata = rdata_q[0];
   assign ch1_rdata = rdata_q[1];
   assign ch0_err   = err_q[0];
   assign ch1_err   = err_q[1];

   assign mem.mem_read      = mem_read_q;
   assign mem.mem_write     = mem_write_q;
   assign mem.mem_address   = mem_address_q;
   assign mem.mem_writedata = mem_writedata_q;

   // State and bus command registers; the command is registered so it stays put under waitrequest.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         grant           <= 1'b0;
         last_grant      <= 1'b1;
         wait_cnt        <= '0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
      end else begin
         state           <= state_nxt;
         grant           <= grant_nxt;
         last_grant      <= last_grant_nxt;
         wait_cnt        <= wait_cnt_nxt;
         mem_read_q      <= mem_read_nxt;
         mem_write_q     <= mem_write_nxt;
         mem_address_q   <= mem_address_nxt;
         mem_writedata_q <= mem_writedata_nxt;
      end
   end

   // Ties go to the channel not granted last; a lone pending slot always wins.
   always_comb begin
      state_nxt         = state;
      grant_nxt         = grant;
      last_grant_nxt    = last_grant;
      wait_cnt_nxt      = wait_cnt;
      mem_read_nxt      = mem_read_q;
      mem_write_nxt     = mem_write_q;
      mem_address_nxt   = mem_address_q;
      mem_writedata_nxt = mem_writedata_q;
      done_wr           = 1'b0;
      done_rd           = 1'b0;
      done_timeout      = 1'b0;
      pick              = 1'b0;
      case (state)
         IDLE: begin
            if (|slot_valid) begin
               pick              = (slot_valid == 2'b11) ? ~last_grant : slot_valid[1];
               grant_nxt         = pick;
               last_grant_nxt    = pick;
               mem_read_nxt      = ~slot_is_wr[pick];
               mem_write_nxt     = slot_is_wr[pick];
               mem_address_nxt   = slot_addr[pick];
               mem_writedata_nxt = slot_wdata[pick];
               state_nxt         = ISSUE;
            end
         end
         ISSUE: begin
            if (!mem.mem_waitrequest) begin
               mem_read_nxt  = 1'b0;
               mem_write_nxt = 1'b0;
               wait_cnt_nxt  = '0;
               if (mem_write_q) begin
                  done_wr   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = RDWAIT;
               end
            end
         end
         RDWAIT: begin
            if (mem.mem_readdatavalid) begin
               done_rd   = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == TIMEOUT_LAST) begin
               done_timeout = 1'b1;
               state_nxt    = IDLE;
            end else begin
               wait_cnt_nxt = wait_cnt + 10'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A slot is only loaded while empty, so strobes during busy (including its last cycle) are dropped.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         slot_valid <= '0;
         slot_is_wr <= '0;
         slot_addr  <= '0;
         slot_wdata <= '0;
         rdata_q    <= '0;
         err_q      <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!slot_valid[i] && (strobe_rd[i] || strobe_wr[i])) begin
               slot_valid[i] <= 1'b1;
               slot_is_wr[i] <= ~strobe_rd[i];
               slot_addr[i]  <= strobe_addr[i];
               slot_wdata[i] <= strobe_rd[i] ? 32'h0 : strobe_wdata[i];
            end
            if (grant == 1'(i)) begin
               if (done_wr) begin
                  slot_valid[i] <= 1'b0;
               end
               if (done_rd) begin
                  slot_valid[i] <= 1'b0;
                  rdata_q[i]    <= mem.mem_readdata;
                  err_q[i]      <= 1'b0;
               end
               if (done_timeout) begin
                  slot_valid[i] <= 1'b0;
                  rdata_q[i]    <= 32'hFFFF_FFFF;
                  err_q[i]      <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Bench for dma_mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of slots, round-robin grants and an Avalon slave.
module tb_dma_mem_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic        ch0_rd = 1'b0, ch0_wr = 1'b0, ch1_rd = 1'b0, ch1_wr = 1'b0;
   logic [31:0] ch0_addr = '0, ch0_wdata = '0, ch1_addr = '0, ch1_wdata = '0;
   logic        ch0_busy, ch0_err, ch1_busy, ch1_err;
   logic [31:0] ch0_rdata, ch1_rdata;

   dma_mem_arbiter_if mem_if ();

   dma_mem_arbiter #(.TIMEOUT(8)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ch0_rd    (ch0_rd),
      .ch0_wr    (ch0_wr),
      .ch0_addr  (ch0_addr),
      .ch0_wdata (ch0_wdata),
      .ch0_busy  (ch0_busy),
      .ch0_rdata (ch0_rdata),
      .ch0_err   (ch0_err),
      .ch1_rd    (ch1_rd),
      .ch1_wr    (ch1_wr),
      .ch1_addr  (ch1_addr),
      .ch1_wdata (ch1_wdata),
      .ch1_busy  (ch1_busy),
      .ch1_rdata (ch1_rdata),
      .ch1_err   (ch1_err),
      .mem       (mem_if.master)
   );

   always #5 clk_sys = ~clk_sys;

   int total = 0;
   int bad   = 0;

   // All stimulus is driven and all outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk_sys);
   endtask

   task automatic clear_inputs();
      ch0_rd = 1'b0; ch0_wr = 1'b0; ch1_rd = 1'b0; ch1_wr = 1'b0;
      mem_if.mem_waitrequest   = 1'b0;
      mem_if.mem_readdatavalid = 1'b0;
      mem_if.mem_readdata      = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic collect_writes(input int n, output logic [31:0] a0, output logic [31:0] a1, output int got);
      got = 0; a0 = '0; a1 = '0;
      for (int i = 0; i < 40 && got < n; i++) begin
         step();
         if (mem_if.mem_write === 1'b1) begin
            if (got == 0) a0 = mem_if.mem_address;
            else          a1 = mem_if.mem_address;
            got++;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      step();
      total++;
      if ({ch0_busy, ch1_busy, ch0_err, ch1_err, mem_if.mem_read, mem_if.mem_write} !== 6'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags: got %b expected 000000",
                  {ch0_busy, ch1_busy, ch0_err, ch1_err, mem_if.mem_read, mem_if.mem_write});
      end
      total++;
      if ({ch0_rdata, ch1_rdata} !== 64'h0) begin
         bad++;
         $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", ch0_rdata, ch1_rdata);
      end
      total++;
      if ({mem_if.mem_address, mem_if.mem_writedata} !== 64'h0) begin
         bad++;
         $display("[TB] FAIL reset_bus: got %h/%h expected 0/0", mem_if.mem_address, mem_if.mem_writedata);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_write();
      int lat, wcyc;
      logic [31:0] seen_addr, seen_wdata;
      seen_addr = '0; seen_wdata = '0; wcyc = 0;
      ch0_wr = 1'b1; ch0_addr = 32'h100; ch0_wdata = 32'hDEADBEEF;
      mem_if.mem_waitrequest = 1'b0;
      step();
      ch0_wr = 1'b0;
      lat = 1;
      while (ch0_busy === 1'b1 && lat < 20) begin
         if (mem_if.mem_write === 1'b1) begin
            wcyc++;
            seen_addr  = mem_if.mem_address;
            seen_wdata = mem_if.mem_writedata;
         end
         step();
         lat++;
      end
      total++;
      if (lat !== 3) begin
         bad++;
         $display("[TB] FAIL write_busy_latency: got %0d expected 3", lat);
      end
      total++;
      if (wcyc !== 1) begin
         bad++;
         $display("[TB] FAIL write_cycles: got %0d expected 1", wcyc);
      end
      total++;
      if (seen_addr !== 32'h100 || seen_wdata !== 32'hDEADBEEF) begin
         bad++;
         $display("[TB] FAIL write_payload: got %h/%h expected 00000100/deadbeef", seen_addr, seen_wdata);
      end
      total++;
      if (mem_if.mem_write !== 1'b0) begin
         bad++;
         $display("[TB] FAIL write_drop: got %b expected 0", mem_if.mem_write);
      end
   endtask

   task automatic test_read_wait();
      int held, unstable;
      held = 0; unstable = 0;
      ch1_rd = 1'b1; ch1_addr = 32'h40;
      mem_if.mem_waitrequest = 1'b1;
      step();
      ch1_rd = 1'b0;
      for (int i = 0; i < 10 && mem_if.mem_read !== 1'b1; i++) step();
      while (mem_if.mem_read === 1'b1 && held < 20) begin
         held++;
         if (mem_if.mem_address !== 32'h40 || mem_if.mem_write !== 1'b0) unstable++;
         if (held == 5) mem_if.mem_waitrequest = 1'b0;
         step();
      end
      total++;
      if (held !== 5 || unstable !== 0) begin
         bad++;
         $display("[TB] FAIL read_hold: got held=%0d unstable=%0d expected held=5 unstable=0", held, unstable);
      end
      step();
      total++;
      if (ch1_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL read_busy_before_valid: got %b expected 1", ch1_busy);
      end
      mem_if.mem_readdatavalid = 1'b1;
      mem_if.mem_readdata      = 32'h12345678;
      step();
      mem_if.mem_readdatavalid = 1'b0;
      total++;
      if (ch1_rdata !== 32'h12345678 || ch1_err !== 1'b0 || ch1_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL read_result: got rdata=%h err=%b busy=%b expected 12345678/0/0",
                  ch1_rdata, ch1_err, ch1_busy);
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] a0, a1;
      int got;
      do_reset();
      for (int p = 0; p < 4; p++) begin
         ch0_wr = 1'b1; ch0_addr = 32'h1000 + 32'(p); ch0_wdata = 32'(p);
         ch1_wr = 1'b1; ch1_addr = 32'h2000 + 32'(p); ch1_wdata = 32'(p);
         step();
         ch0_wr = 1'b0; ch1_wr = 1'b0;
         collect_writes(2, a0, a1, got);
         total++;
         if (got !== 2 || a0 !== 32'h1000 + 32'(p) || a1 !== 32'h2000 + 32'(p)) begin
            bad++;
            $display("[TB] FAIL rr_pair%0d: got n=%0d %h,%h expected 2 %h,%h",
                     p, got, a0, a1, 32'h1000 + 32'(p), 32'h2000 + 32'(p));
         end
         step();
      end
      ch0_wr = 1'b1; ch0_addr = 32'h3000;
      step();
      ch0_wr = 1'b0;
      collect_writes(1, a0, a1, got);
      step();
      ch0_wr = 1'b1; ch0_addr = 32'h3001;
      ch1_wr = 1'b1; ch1_addr = 32'h4001;
      step();
      ch0_wr = 1'b0; ch1_wr = 1'b0;
      collect_writes(2, a0, a1, got);
      total++;
      if (got !== 2 || a0 !== 32'h4001 || a1 !== 32'h3001) begin
         bad++;
         $display("[TB] FAIL rr_after_ch0: got n=%0d %h,%h expected 2 00004001,00003001", got, a0, a1);
      end
      step();
   endtask

   task automatic test_timeout();
      int steps;
      ch0_rd = 1'b1; ch0_addr = 32'h80;
      mem_if.mem_waitrequest = 1'b0;
      step();
      ch0_rd = 1'b0;
      for (int i = 0; i < 10 && mem_if.mem_read !== 1'b1; i++) step();
      steps = 0;
      do begin
         step();
         steps++;
      end while (ch0_busy === 1'b1 && steps < 30);
      total++;
      if (steps !== 9) begin
         bad++;
         $display("[TB] FAIL timeout_latency: got %0d expected 9", steps);
      end
      total++;
      if (ch0_rdata !== 32'hFFFFFFFF || ch0_err !== 1'b1 || ch0_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL timeout_result: got rdata=%h err=%b busy=%b expected ffffffff/1/0",
                  ch0_rdata, ch0_err, ch0_busy);
      end
      ch0_rd = 1'b1; ch0_addr = 32'h84;
      step();
      ch0_rd = 1'b0;
      for (int i = 0; i < 10 && mem_if.mem_read !== 1'b1; i++) step();
      step();
      mem_if.mem_readdatavalid = 1'b1;
      mem_if.mem_readdata      = 32'h0BADF00D;
      step();
      mem_if.mem_readdatavalid = 1'b0;
      total++;
      if (ch0_rdata !== 32'h0BADF00D || ch0_err !== 1'b0 || ch0_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL timeout_recover: got rdata=%h err=%b busy=%b expected 0badf00d/0/0",
                  ch0_rdata, ch0_err, ch0_busy);
      end
   endtask

   task automatic test_rd_wr_same();
      int reads, writes;
      logic prev_rd;
      logic [31:0] rd_addr;
      reads = 0; writes = 0; prev_rd = 1'b0; rd_addr = '0;
      ch0_rd = 1'b1; ch0_wr = 1'b1; ch0_addr = 32'h200; ch0_wdata = 32'h55;
      mem_if.mem_waitrequest = 1'b0;
      step();
      ch0_rd = 1'b0; ch0_wr = 1'b1; ch0_addr = 32'h300; ch0_wdata = 32'h66;
      step();
      ch0_wr = 1'b0;
      for (int i = 0; i < 30; i++) begin
         mem_if.mem_readdatavalid = 1'b0;
         if (mem_if.mem_write === 1'b1) writes++;
         if (mem_if.mem_read === 1'b1 && !prev_rd) begin
            reads++;
            rd_addr = mem_if.mem_address;
         end
         if (prev_rd && mem_if.mem_read !== 1'b1) begin
            mem_if.mem_readdatavalid = 1'b1;
            mem_if.mem_readdata      = 32'h77;
         end
         prev_rd = (mem_if.mem_read === 1'b1);
         step();
      end
      mem_if.mem_readdatavalid = 1'b0;
      total++;
      if (reads !== 1 || writes !== 0 || rd_addr !== 32'h200) begin
         bad++;
         $display("[TB] FAIL rdwr_collision: got reads=%0d writes=%0d addr=%h expected 1/0/00000200",
                  reads, writes, rd_addr);
      end
      total++;
      if (ch0_rdata !== 32'h77 || ch0_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rdwr_result: got rdata=%h busy=%b expected 00000077/0", ch0_rdata, ch0_busy);
      end
   endtask

   task automatic test_reset_mid();
      ch1_rd = 1'b1; ch1_addr = 32'h44;
      mem_if.mem_waitrequest = 1'b0;
      step();
      ch1_rd = 1'b0;
      for (int i = 0; i < 10 && mem_if.mem_read !== 1'b1; i++) step();
      step();
      reset = 1'b1;
      #1;
      total++;
      if ({ch0_busy, ch1_busy, ch0_err, ch1_err, mem_if.mem_read, mem_if.mem_write} !== 6'b0 ||
          {ch0_rdata, ch1_rdata, mem_if.mem_address, mem_if.mem_writedata} !== 128'h0) begin
         bad++;
         $display("[TB] FAIL reset_async: got busy=%b%b rdata=%h/%h addr=%h expected all 0",
                  ch0_busy, ch1_busy, ch0_rdata, ch1_rdata, mem_if.mem_address);
      end
      step();
      reset = 1'b0;
      mem_if.mem_readdatavalid = 1'b1;
      mem_if.mem_readdata      = 32'hAAAA5555;
      step();
      mem_if.mem_readdatavalid = 1'b0;
      step();
      total++;
      if ({ch0_rdata, ch1_rdata} !== 64'h0 || {ch0_busy, ch1_busy, ch0_err, ch1_err} !== 4'b0 ||
          {mem_if.mem_read, mem_if.mem_write} !== 2'b0) begin
         bad++;
         $display("[TB] FAIL reset_stray_valid: got rdata=%h/%h busy=%b%b cmd=%b%b expected 0",
                  ch0_rdata, ch1_rdata, ch0_busy, ch1_busy, mem_if.mem_read, mem_if.mem_write);
      end
   endtask

   // Model: each channel is a one-deep slot; the bench plays the memory slave and
   // predicts busy/rdata/err plus which slot each new bus command must come from.
   task automatic test_random();
      bit          mb[2], mop_wr[2], merr[2], prev_mb[2], busy_now[2];
      logic [31:0] maddr[2], mwd[2], mrd[2];
      bit          mlast, prev_act, prev_wait, prev_rd, prev_wr, act, rd_pend, resp, draining;
      logic [31:0] prev_addr, prev_wd, rd_data;
      int          cur, rd_cnt, e, r;
      bit          s_rd[2], s_wr[2];
      logic [31:0] s_addr[2], s_wd[2];
      do_reset();
      for (int c = 0; c < 2; c++) begin
         mb[c] = 0; mop_wr[c] = 0; merr[c] = 0; prev_mb[c] = 0; maddr[c] = '0; mwd[c] = '0; mrd[c] = '0;
      end
      mlast = 1; prev_act = 0; prev_wait = 0; prev_rd = 0; prev_wr = 0; prev_addr = '0; prev_wd = '0;
      rd_pend = 0; rd_cnt = 0; rd_data = '0; cur = 0;
      for (int cyc = 0; cyc < 1560; cyc++) begin
         draining = (cyc >= 1500);
         act = (mem_if.mem_read === 1'b1) || (mem_if.mem_write === 1'b1);
         total++;
         if (mem_if.mem_read === 1'b1 && mem_if.mem_write === 1'b1) begin
            bad++;
            $display("[TB] FAIL rnd_exclusive cyc=%0d: got rd=1 wr=1 expected not both", cyc);
         end
         total++;
         if ({ch1_busy, ch0_busy} !== {mb[1], mb[0]}) begin
            bad++;
            $display("[TB] FAIL rnd_busy cyc=%0d: got %b%b expected %b%b", cyc, ch1_busy, ch0_busy, mb[1], mb[0]);
         end
         total++;
         if (ch0_rdata !== mrd[0] || ch1_rdata !== mrd[1] || ch0_err !== merr[0] || ch1_err !== merr[1]) begin
            bad++;
            $display("[TB] FAIL rnd_result cyc=%0d: got %h/%b %h/%b expected %h/%b %h/%b", cyc,
                     ch0_rdata, ch0_err, ch1_rdata, ch1_err, mrd[0], merr[0], mrd[1], merr[1]);
         end
         if (act && !prev_act) begin
            total++;
            if (prev_mb[0] && prev_mb[1]) e = mlast ? 0 : 1;
            else if (prev_mb[0])          e = 0;
            else if (prev_mb[1])          e = 1;
            else                          e = -1;
            if (e < 0) begin
               bad++;
               $display("[TB] FAIL rnd_spurious_cmd cyc=%0d: got addr=%h expected no command", cyc, mem_if.mem_address);
               e = 0;
            end else if (mem_if.mem_write !== mop_wr[e] || mem_if.mem_address !== maddr[e] ||
                         (mop_wr[e] && mem_if.mem_writedata !== mwd[e])) begin
               bad++;
               $display("[TB] FAIL rnd_grant cyc=%0d: got wr=%b addr=%h data=%h expected ch%0d wr=%b addr=%h data=%h",
                        cyc, mem_if.mem_write, mem_if.mem_address, mem_if.mem_writedata,
                        e, mop_wr[e], maddr[e], mwd[e]);
            end
            mlast = (e == 1);
            cur   = e;
         end else if (act && prev_act && prev_wait) begin
            total++;
            if (mem_if.mem_read !== prev_rd || mem_if.mem_write !== prev_wr ||
                mem_if.mem_address !== prev_addr || mem_if.mem_writedata !== prev_wd) begin
               bad++;
               $display("[TB] FAIL rnd_hold cyc=%0d: got addr=%h expected %h", cyc, mem_if.mem_address, prev_addr);
            end
         end
         // Slave response: a real one when a read is owed, otherwise occasional stray valids.
         resp = 0;
         mem_if.mem_readdatavalid = 1'b0;
         mem_if.mem_readdata      = $urandom;
         if (rd_pend) begin
            if (rd_cnt == 0) begin
               mem_if.mem_readdatavalid = 1'b1;
               mem_if.mem_readdata      = rd_data;
               resp    = 1;
               rd_pend = 0;
            end else begin
               rd_cnt--;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            mem_if.mem_readdatavalid = 1'b1;
         end
         mem_if.mem_waitrequest = draining ? 1'b0 : ($urandom_range(0, 2) == 0);
         for (int c = 0; c < 2; c++) begin
            r = draining ? 7 : $urandom_range(0, 7);
            s_rd[c]   = (r == 0) || (r == 2);
            s_wr[c]   = (r == 1) || (r == 2);
            s_addr[c] = {1'(c), 31'($urandom)};
            s_wd[c]   = $urandom;
         end
         ch0_rd = s_rd[0]; ch0_wr = s_wr[0]; ch0_addr = s_addr[0]; ch0_wdata = s_wd[0];
         ch1_rd = s_rd[1]; ch1_wr = s_wr[1]; ch1_addr = s_addr[1]; ch1_wdata = s_wd[1];
         busy_now = mb;
         prev_mb  = mb;
         if (act && !mem_if.mem_waitrequest) begin
            if (mem_if.mem_write === 1'b1) begin
               mb[cur] = 0;
            end else begin
               rd_pend = 1;
               rd_cnt  = $urandom_range(0, 3);
               rd_data = $urandom;
            end
         end
         if (resp) begin
            mrd[cur]  = mem_if.mem_readdata;
            merr[cur] = 0;
            mb[cur]   = 0;
         end
         for (int c = 0; c < 2; c++) begin
            if (!busy_now[c] && (s_rd[c] || s_wr[c])) begin
               mb[c]     = 1;
               mop_wr[c] = !s_rd[c];
               maddr[c]  = s_addr[c];
               mwd[c]    = s_wd[c];
            end
         end
         prev_act  = act;
         prev_wait = mem_if.mem_waitrequest;
         prev_rd   = (mem_if.mem_read === 1'b1);
         prev_wr   = (mem_if.mem_write === 1'b1);
         prev_addr = mem_if.mem_address;
         prev_wd   = mem_if.mem_writedata;
         step();
      end
      clear_inputs();
      total++;
      if (mb[0] || mb[1] || ch0_busy !== 1'b0 || ch1_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rnd_drain: got busy=%b%b model=%b%b expected all 0", ch1_busy, ch0_busy, mb[1], mb[0]);
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_write();
      test_read_wait();
      test_round_robin();
      test_timeout();
      test_rd_wr_same();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
